// File: rtl/sseg_scan_nd_if.sv
// Bus bundle between a display-value producer and sseg_scan_nd.
// Defining SSEG_BRIGHT_EN adds the 3-bit brightness input.
interface sseg_scan_nd_if #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14,
    parameter int SEL_W    = $clog2(N_DIGITS)
);
    logic [BIN_W-1:0]    bin_val;
    logic                sign;
    logic                load;
    logic                blank_en;
    logic                dp_en;
    logic [SEL_W-1:0]    dp_sel;
`ifdef SSEG_BRIGHT_EN
    logic [2:0]          bright;
`endif
    logic                busy;
    logic                done;
    logic                ovf;
    logic [7:0]          ssegs;
    logic [N_DIGITS-1:0] disp_en;

`ifdef SSEG_BRIGHT_EN
    modport master (output bin_val, sign, load, blank_en, dp_en, dp_sel, bright,
                    input  busy, done, ovf, ssegs, disp_en);
    modport slave  (input  bin_val, sign, load, blank_en, dp_en, dp_sel, bright,
                    output busy, done, ovf, ssegs, disp_en);
`else
    modport master (output bin_val, sign, load, blank_en, dp_en, dp_sel,
                    input  busy, done, ovf, ssegs, disp_en);
    modport slave  (input  bin_val, sign, load, blank_en, dp_en, dp_sel,
                    output busy, done, ovf, ssegs, disp_en);
`endif
endinterface

// File: rtl/sseg_scan_nd.sv
// Signed binary to N-digit BCD (sequential double dabble) with multiplexed common-anode scan.
// Optional macro SSEG_BRIGHT_EN adds a 3-bit duty-cycle brightness control.
module sseg_scan_nd #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14,
    parameter int DIV_W    = 14,
    parameter int SEL_W    = $clog2(N_DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    sseg_scan_nd_if.slave bus
);
    localparam int             CNT_W = $clog2(BIN_W + 1);
    localparam int             BCD_W = 4 * (N_DIGITS + 1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FINAL} state_t;

    state_t                   state;
    logic                     load_q;
    logic [BIN_W-1:0]         bin_q;
    logic                     sign_q;
    logic [BIN_W-1:0]         bin_sr;
    logic [BCD_W-1:0]         bcd;
    logic [BCD_W-1:0]         bcd_adj;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     neg;
    logic                     busy_r;
    logic                     done_r;
    logic                     ovf_r;
    logic                     ovf_next;
    logic [N_DIGITS-1:0][3:0] disp_reg;
    logic [N_DIGITS-1:0][3:0] disp_next;

    logic [DIV_W-1:0]         div_cnt;
    logic [DIV_W-1:0]         div_next;
    logic [SEL_W-1:0]         scan_idx;
    logic [SEL_W-1:0]         idx_next;
    logic [7:0]               seg_raw;
    logic                     dp_bit;
    logic                     duty_on;
    logic [7:0]               ssegs_r;
    logic [N_DIGITS-1:0]      disp_en_r;

    function automatic logic [7:0] seg_code(input logic [3:0] code);
        case (code)
            4'h0:    seg_code = 8'h03;
            4'h1:    seg_code = 8'h9F;
            4'h2:    seg_code = 8'h25;
            4'h3:    seg_code = 8'h0D;
            4'h4:    seg_code = 8'h99;
            4'h5:    seg_code = 8'h49;
            4'h6:    seg_code = 8'h41;
            4'h7:    seg_code = 8'h1F;
            4'h8:    seg_code = 8'h01;
            4'h9:    seg_code = 8'h09;
            4'hA:    seg_code = 8'hFD;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bcd_adj = bcd;
        for (int j = 0; j <= N_DIGITS; j++) begin
            if (bcd[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
        end
    end

    // Final formatting: digit 0 is the leftmost, i.e. the most significant BCD nibble.
    always_comb begin
        int lead_pos;
        logic [3:0] digit;
        ovf_next  = (bcd[4*N_DIGITS +: 4] != 4'd0) ||
                    (neg && (bcd[4*(N_DIGITS-1) +: 4] != 4'd0));
        disp_next = '1;
        lead_pos  = N_DIGITS - 1;
        digit     = 4'd0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (bcd[4*(N_DIGITS-1-i) +: 4] != 4'd0) lead_pos = i;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            digit = bcd[4*(N_DIGITS-1-i) +: 4];
            if (ovf_next)
                disp_next[i] = 4'hA;
            else if (neg && ((bus.blank_en && i == lead_pos - 1) || (!bus.blank_en && i == 0)))
                disp_next[i] = 4'hA;
            else if (bus.blank_en && i < lead_pos)
                disp_next[i] = 4'hF;
            else
                disp_next[i] = digit;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            load_q   <= 1'b0;
            bin_q    <= '0;
            sign_q   <= 1'b0;
            bin_sr   <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            neg      <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
            // NOTE: the display register is small and must power up blank, so it is reset like any flop.
            disp_reg <= {N_DIGITS{4'hF}};
        end else begin
            done_r <= 1'b0;
            load_q <= bus.load & ~busy_r;
            if (bus.load && !busy_r) begin
                bin_q  <= bus.bin_val;
                sign_q <= bus.sign;
            end
            case (state)
                IDLE: if (load_q) begin
                    bin_sr  <= bin_q;
                    neg     <= sign_q;
                    bcd     <= '0;
                    bit_cnt <= '0;
                    busy_r  <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
                    bit_cnt       <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(BIN_W - 1)) state <= FINAL;
                end
                FINAL: begin
                    disp_reg <= disp_next;
                    ovf_r    <= ovf_next;
                    done_r   <= 1'b1;
                    busy_r   <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign div_next = div_cnt + 1'b1;
    assign idx_next = (&div_cnt) ? ((scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1) : scan_idx;
    assign seg_raw  = seg_code(disp_reg[idx_next]);
    assign dp_bit   = ~(bus.dp_en && (idx_next == bus.dp_sel));

`ifdef SSEG_BRIGHT_EN
    logic [DIV_W+2:0] phase_ext;
    assign phase_ext = {div_next, 3'b000};
    assign duty_on   = (phase_ext[DIV_W+2 -: 3] <= bus.bright);
`else
    assign duty_on = 1'b1;
`endif

    // Outputs are computed from the next index so ssegs and disp_en move on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            scan_idx  <= '0;
            ssegs_r   <= 8'hFF;
            disp_en_r <= '1;
        end else begin
            div_cnt  <= div_next;
            scan_idx <= idx_next;
            if (duty_on) begin
                ssegs_r   <= {seg_raw[7:1], dp_bit};
                disp_en_r <= ~(N_DIGITS'(1) << idx_next);
            end else begin
                disp_en_r <= '1;
            end
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.ovf     = ovf_r;
    assign bus.ssegs   = ssegs_r;
    assign bus.disp_en = disp_en_r;
endmodule

// File: tb/tb_sseg_scan_nd.sv
// Self-checking bench for sseg_scan_nd: directed scenarios plus randomized conversions
// compared against a decimal-arithmetic model of the expected display.
module tb_sseg_scan_nd;
    localparam int N     = 4;
    localparam int BIN_W = 14;
    localparam int DIV_W = 2;
    localparam int SEL_W = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    sseg_scan_nd_if #(.N_DIGITS(N), .BIN_W(BIN_W), .SEL_W(SEL_W)) bus ();

    sseg_scan_nd #(.N_DIGITS(N), .BIN_W(BIN_W), .DIV_W(DIV_W), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;  3: return 8'h0D;
            4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1F;
            8: return 8'h01;  9: return 8'h09;  10: return 8'hFD;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic bit model_ovf(input int v, input bit s);
        return (v >= pow10(N)) || (s && v >= pow10(N - 1));
    endfunction

    function automatic logic [N-1:0][7:0] model_disp(input int v, input bit s, input bit b);
        logic [N-1:0][7:0] r;
        int ndig, first, t;
        r = '1;
        if (model_ovf(v, s)) begin
            for (int i = 0; i < N; i++) r[i] = 8'hFD;
            return r;
        end
        ndig = 1;
        t = v;
        while (t >= 10) begin
            t = t / 10;
            ndig++;
        end
        first = N - ndig;
        for (int i = 0; i < N; i++) begin
            r[i] = seg_of((v / pow10(N - 1 - i)) % 10);
            if (b && i < first) r[i] = 8'hFF;
        end
        if (s) r[b ? first - 1 : 0] = 8'hFD;
        return r;
    endfunction

    // Called at a falling edge; load is sampled on the next rising edge.
    task automatic pulse_load(input int v, input bit s, input bit b);
        bus.bin_val  = BIN_W'(v);
        bus.sign     = s;
        bus.blank_en = b;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
        bus.bin_val  = BIN_W'($urandom);
        bus.sign     = 1'($urandom);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.done !== 1'b1 && cyc < 60);
    endtask

    task automatic check_display(input string name, input logic [N-1:0][7:0] exp_d,
                                 input bit dpe, input int dps);
        logic [N-1:0] seen;
        logic [7:0]   want;
        int           idx;
        seen = '0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total++;
            if ($countones(~bus.disp_en) != 1 || bus.done !== 1'b0) begin
                bad++;
                $display("FAIL %s enable/done: disp_en=%b done=%b, required one low bit and done=0",
                         name, bus.disp_en, bus.done);
            end else begin
                idx = 0;
                for (int i = 0; i < N; i++) if (!bus.disp_en[i]) idx = i;
                seen[idx] = 1'b1;
                want = {exp_d[idx][7:1], (dpe && idx == dps) ? 1'b0 : 1'b1};
                total++;
                if (bus.ssegs !== want) begin
                    bad++;
                    $display("FAIL %s digit %0d: ssegs=%h required %h", name, idx, bus.ssegs, want);
                end
            end
        end
        total++;
        if (seen !== '1) begin
            bad++;
            $display("FAIL %s scan coverage: seen=%b required 1111", name, seen);
        end
    endtask

    task automatic convert(input string name, input int v, input bit s, input bit b,
                           input bit dpe, input int dps);
        int cyc;
        bus.dp_en  = dpe;
        bus.dp_sel = SEL_W'(dps);
        @(negedge clk);
        pulse_load(v, s, b);
        wait_done(cyc);
        total++;
        if (cyc != 16 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s latency: done after %0d cycles busy=%b, required 16 and busy=0",
                     name, cyc, bus.busy);
        end
        total++;
        if (bus.ovf !== model_ovf(v, s)) begin
            bad++;
            $display("FAIL %s ovf: got %b required %b", name, bus.ovf, model_ovf(v, s));
        end
        check_display(name, model_disp(v, s, b), dpe, dps);
    endtask

    task automatic test_reset();
        #23;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0 ||
            bus.ssegs !== 8'hFF || bus.disp_en !== 4'b1111) begin
            bad++;
            $display("FAIL reset values: busy=%b done=%b ovf=%b ssegs=%h disp_en=%b, required 0 0 0 ff 1111",
                     bus.busy, bus.done, bus.ovf, bus.ssegs, bus.disp_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.disp_en !== 4'b1110 || bus.ssegs !== 8'hFF) begin
            bad++;
            $display("FAIL reset first digit: disp_en=%b ssegs=%h required 1110 ff", bus.disp_en, bus.ssegs);
        end
        check_display("reset blank", {N{8'hFF}}, 1'b0, 0);
    endtask

    task automatic test_convert_1234();
        int cyc, nbusy;
        bus.dp_en = 1'b0;
        @(negedge clk);
        pulse_load(1234, 1'b0, 1'b1);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL 1234 busy in load cycle: got %b required 0", bus.busy);
        end
        cyc = 0;
        nbusy = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.busy === 1'b1) nbusy++;
        end
        total++;
        if (cyc != 16 || nbusy != 15 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL 1234 timing: done at %0d busy cycles %0d busy=%b, required 16 15 0",
                     cyc, nbusy, bus.busy);
        end
        total++;
        if (bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL 1234 ovf: got %b required 0", bus.ovf);
        end
        check_display("1234", model_disp(1234, 1'b0, 1'b1), 1'b0, 0);
    endtask

    task automatic test_blank_sign();
        convert("neg7 blank",    7, 1'b1, 1'b1, 1'b0, 0);
        convert("neg7 noblank",  7, 1'b1, 1'b0, 1'b0, 0);
        convert("neg0 blank",    0, 1'b1, 1'b1, 1'b0, 0);
        convert("neg0 noblank",  0, 1'b1, 1'b0, 1'b0, 0);
        convert("pos0 blank",    0, 1'b0, 1'b1, 1'b0, 0);
        convert("pos40 blank",  40, 1'b0, 1'b1, 1'b0, 0);
    endtask

    task automatic test_overflow();
        convert("ovf 10000",     10000, 1'b0, 1'b1, 1'b0, 0);
        convert("neg 999",       999,   1'b1, 1'b1, 1'b0, 0);
        convert("neg 1000 ovf",  1000,  1'b1, 1'b1, 1'b0, 0);
        convert("pos 9999",      9999,  1'b0, 1'b1, 1'b0, 0);
        convert("max 16383 ovf", 16383, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_dp();
        convert("dp sel2",    1234, 1'b0, 1'b1, 1'b1, 2);
        convert("dp on dash", 5,    1'b1, 1'b1, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus.dp_en = 1'b0;
        @(negedge clk);
        pulse_load(1234, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        pulse_load(5678, 1'b0, 1'b1);
        wait_done(cyc);
        total++;
        if (cyc != 13) begin
            bad++;
            $display("FAIL busy-load done timing: done %0d cycles after ignored load, required 13", cyc);
        end
        check_display("busy-load ignored", model_disp(1234, 1'b0, 1'b1), 1'b0, 0);

        @(negedge clk);
        pulse_load(1111, 1'b0, 1'b1);
        wait_done(cyc);
        pulse_load(5678, 1'b0, 1'b1);
        wait_done(cyc);
        total++;
        if (cyc != 16 || bus.ovf !== 1'b0) begin
            bad++;
            $display("FAIL done-cycle load: done after %0d ovf=%b, required 16 and 0", cyc, bus.ovf);
        end
        check_display("done-cycle load", model_disp(5678, 1'b0, 1'b1), 1'b0, 0);
    endtask

    task automatic test_random();
        int v, mode, dps;
        bit s, b, dpe;
        for (int n = 0; n < 24; n++) begin
            mode = $urandom_range(0, 3);
            case (mode)
                0:       v = $urandom_range(0, 9);
                1:       v = $urandom_range(0, 999);
                2:       v = $urandom_range(0, 9999);
                default: v = $urandom_range(0, 16383);
            endcase
            s   = 1'($urandom);
            b   = 1'($urandom);
            dpe = 1'($urandom);
            dps = $urandom_range(0, N - 1);
            convert($sformatf("rand%0d v=%0d s=%0d b=%0d", n, v, s, b), v, s, b, dpe, dps);
        end
    endtask

    task automatic test_reset_async();
        convert("pre-reset ovf", 12000, 1'b0, 1'b1, 1'b0, 0);
        @(negedge clk);
        pulse_load(4321, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0 ||
            bus.ssegs !== 8'hFF || bus.disp_en !== 4'b1111) begin
            bad++;
            $display("FAIL async reset: busy=%b done=%b ovf=%b ssegs=%h disp_en=%b, required 0 0 0 ff 1111",
                     bus.busy, bus.done, bus.ovf, bus.ssegs, bus.disp_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.disp_en !== 4'b1110 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL post-reset restart: disp_en=%b busy=%b, required 1110 0", bus.disp_en, bus.busy);
        end
        check_display("aborted conversion", {N{8'hFF}}, 1'b0, 0);
    endtask

`ifdef SSEG_BRIGHT_EN
    initial bus.bright = 3'd7;
`endif

    initial begin
        bus.bin_val  = '0;
        bus.sign     = 1'b0;
        bus.load     = 1'b0;
        bus.blank_en = 1'b1;
        bus.dp_en    = 1'b0;
        bus.dp_sel   = '0;
        test_reset();
        test_convert_1234();
        test_blank_sign();
        test_overflow();
        test_dp();
        test_back_to_back();
        test_random();
        test_reset_async();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sseg_scan_nd.md
Name: sseg_scan_nd

Overview:
- Parametrised successor of the four-digit multiplexed seven-segment driver.
- Converts a BIN_W-bit unsigned binary value plus sign to N_DIGITS BCD digits using an iterative sequential double-dabble engine; the combinational compare chains are not used.
- Holds the result in a display register and scans it across N_DIGITS common-anode digits with a refresh divider.
- Sits between vending-machine datapath counters and the board display pins.

Parameters:
- N_DIGITS, 4: number of displayed digits (2..8).
- BIN_W, 14: width of the binary input.
- DIV_W, 14: refresh divider width; the scan advances once every 2^DIV_W clocks.
- SEL_W, $clog2(N_DIGITS): width of the digit index and dp_sel.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- bin_val  in  BIN_W  unsigned magnitude to display.
- sign  in  1  1 = negative; sampled together with bin_val.
- load  in  1  start-conversion strobe.
- blank_en  in  1  1 = suppress leading zeros.
- dp_en  in  1  decimal point enable.
- dp_sel  in  SEL_W  digit index carrying the decimal point (0 = leftmost).
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when the display register updates.
- ovf  out  1  last conversion overflowed; held until the next completion.
- ssegs  out  8  active-low segments {a,b,c,d,e,f,g,dp}; bit0 = dp.
- disp_en  out  N_DIGITS  active-low digit enables; bit i = digit i, digit 0 leftmost.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: busy=0, done=0, ovf=0, ssegs=8'hFF, disp_en all ones, scan index 0, divider 0.
  - All display-register digits reset to blank (code F).
  - FSM resets to IDLE.
- FSM states: IDLE, SHIFT, FINAL.
  - IDLE: when load=1, capture bin_val into the shift register, capture sign, clear the BCD register, clear the bit counter, go to SHIFT.
  - SHIFT: one double-dabble step per cycle. Each BCD nibble >=5 gets +3, then {bcd,bin} shifts left by 1. After BIN_W steps, go to FINAL.
  - FINAL: apply blanking, sign and overflow; write the display register; pulse done; go to IDLE.
- BCD register width: N_DIGITS+1 nibbles. The extra nibble detects overflow.
- Timing: load sampled at edge k. busy=1 from k+1 through k+BIN_W+1. done=1 and the new display register are both visible at k+BIN_W+2, with busy=0 in that cycle.
- load while busy: ignored, no queueing.
- load in the same cycle that done pulses: accepted, because the FSM is in IDLE.
- Overflow: ovf=1 and all digits show dash (code A) when either condition holds:
  - value >= 10^N_DIGITS;
  - sign=1 and value >= 10^(N_DIGITS-1).
- Sign handling, no overflow, sign=1:
  - blank_en=1: a dash goes in the digit immediately left of the most significant nonzero digit.
  - blank_en=0: the dash goes in digit 0.
  - Value 0 with sign=1 displays as "-0" (blank_en=1) or "-000" (blank_en=0).
- Blanking: with blank_en=1, leading zeros are blank (F). The rightmost digit is never blanked.
- Scan:
  - The divider free-runs. Its terminal count (all ones) advances the scan index, which wraps from N_DIGITS-1 to 0.
  - disp_en has exactly one bit low at all times after reset: bit[index].
  - ssegs shows the display-register digit at index, registered, so ssegs and disp_en change on the same edge.
- Segment codes (active-low): 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A(dash)=FD, F(blank)=FF, any other code=FF.
- Decimal point: dp bit = ~dp_en when index==dp_sel, else 1. It applies to dash and blank digits as well.
- The display register is never partially updated: the old value shows until done.
- Reset mid-conversion aborts the conversion and restores all reset values.

Optional Feature:
- Macro SSEG_BRIGHT_EN.
- Defined:
  - Adds input bright [2:0].
  - The digit enable is asserted only while the top 3 divider bits are <= bright. bright=7 gives full duty; bright=0 gives 1/8 duty.
  - Outside the duty window, disp_en is all ones and ssegs is unchanged.
- Undefined: no bright port; full duty.

Test Plan:
- Bench uses N_DIGITS=4, BIN_W=14, DIV_W=2.
- Reset check: assert rst_n=0 mid-scan -> ssegs=FF, disp_en=1111, busy=0 immediately (asynchronous). After release, digit 0 is enabled first and all digits read FF.
- Convert 1234: load bin_val=1234, sign=0 -> busy for exactly 15 cycles, done 16 cycles after the load edge. Scan shows 9F, 25, 0D, 99 on disp_en 1110, 1101, 1011, 0111.
- Blanking and sign: bin_val=7, sign=1, blank_en=1 -> digits FF, FF, FD, 1F. Same with blank_en=0 -> FD, 03, 03, 1F.
- Overflow: bin_val=10000 -> ovf=1, all digits FD. Then bin_val=999, sign=1 -> ovf=0, digits FD, 09, 09, 09. Then bin_val=1000, sign=1 -> ovf=1.
- Handshake: pulse load=1234, then load=5678 three cycles later -> second load ignored, display shows 1234. Load in the done cycle -> accepted, 5678 appears 16 cycles later. dp_sel=2, dp_en=1 -> bit0 low only on digit 2.
- SSEG_BRIGHT_EN build: bright=0 -> each digit enabled for 1 of every 8 divider phases. bright=7 -> continuous enable.
